// File: rtl/hid_host_tx_if.sv
// Command/status bundle for hid_host_tx.
// Handshake: a command byte transfers on any rising dspclk edge where
// cmd_valid & cmd_ready are both 1. The producer holds cmd_valid/cmd_data
// stable until that edge. cmd_ready is 1 only while the sequencer is idle.
// done is a one-cycle pulse. ack_err and timeout_err qualify done and read 0
// whenever done is 0. dbg_state mirrors the sequencer state register.
interface hid_host_tx_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       done;
  logic       ack_err;
  logic       timeout_err;
  logic [2:0] dbg_state;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, done, ack_err, timeout_err, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, done, ack_err, timeout_err, dbg_state
  );
endinterface

// File: rtl/hid_host_tx.sv
// hid_host_tx: PS/2 host-to-device command sequencer.
// Sends one byte on the open-drain hid_clk/hid_dat bus with this sequence:
// clock inhibit, request-to-send, 8 data bits LSB first, odd parity, stop,
// then device ACK. The scan-code receiver is held off for the whole transfer.
// Optional feature macro: HID_TX_RETRY_EN. When it is defined, a NAK or a
// timeout resends the same byte up to RETRY_MAX times before done is reported.
module hid_host_tx #(
  parameter int INHIBIT_CNT = 10000,
  parameter int TIMEOUT_CNT = 1500000,
  parameter int RETRY_MAX   = 2
) (
  input  logic         dspclk,
  input  logic         reset,
  input  logic         hid_clk,
  input  logic         hid_dat,
  output logic         hid_clk_oe,
  output logic         hid_dat_oe,
  output logic         rx_inhibit,
  hid_host_tx_if.slave cmd
);

  localparam int IW = $clog2(INHIBIT_CNT + 1);
  localparam int TW = $clog2(TIMEOUT_CNT + 1);
  localparam logic [IW-1:0] I_LAST = IW'(INHIBIT_CNT - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CNT - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CNT);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, DATA, PARITY, STOP, ACK, FINISH
  } state_t;

  state_t        state_q, state_d;
  logic          clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
  logic [IW-1:0] icnt_q, icnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bitcnt_q, bitcnt_d, bit_nxt;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d, nak_q, nak_d;
  logic          clk_oe_d, dat_oe_d, rx_inh_d;
  logic          ready_q, ready_d, done_q, done_d;
  logic          ack_err_q, ack_err_d, tout_q, tout_d;
  logic          c_fall, c_rise, bus_edge, timed, t_expire;
  logic          end_ok, end_nak, end_to;

`ifdef HID_TX_RETRY_EN
  localparam int RW = $clog2(RETRY_MAX + 1) + 1;
  logic [RW-1:0] retry_q, retry_d;
`else
  logic unused_retry;
  assign unused_retry = (RETRY_MAX != 0);
`endif

  assign c_fall   = clk_prev & ~clk_s2;
  assign c_rise   = ~clk_prev & clk_s2;
  assign bus_edge = c_fall | c_rise;
  assign bit_nxt  = bitcnt_q + 3'd1;
  assign timed    = (state_q == RTS) || (state_q == DATA) || (state_q == PARITY) ||
                    (state_q == STOP) || (state_q == ACK) || (state_q == FINISH);
  // tcnt holds the number of cycles since the last bus edge, so firing one
  // count early lands done exactly TIMEOUT_CNT cycles after that edge.
  assign t_expire = timed && (tcnt_q == T_LAST);

  assign cmd.cmd_ready   = ready_q;
  assign cmd.done        = done_q;
  assign cmd.ack_err     = ack_err_q;
  assign cmd.timeout_err = tout_q;
  assign cmd.dbg_state   = state_q;

  // Two-flop synchronisers, edge history, state and registered outputs.
  always_ff @(posedge dspclk) begin
    if (reset) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      clk_prev   <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      state_q    <= IDLE;
      icnt_q     <= '0;
      tcnt_q     <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      nak_q      <= 1'b0;
      hid_clk_oe <= 1'b0;
      hid_dat_oe <= 1'b0;
      rx_inhibit <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      tout_q     <= 1'b0;
`ifdef HID_TX_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      clk_s1     <= hid_clk;
      clk_s2     <= clk_s1;
      clk_prev   <= clk_s2;
      dat_s1     <= hid_dat;
      dat_s2     <= dat_s1;
      state_q    <= state_d;
      icnt_q     <= icnt_d;
      tcnt_q     <= tcnt_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      nak_q      <= nak_d;
      hid_clk_oe <= clk_oe_d;
      hid_dat_oe <= dat_oe_d;
      rx_inhibit <= rx_inh_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      tout_q     <= tout_d;
`ifdef HID_TX_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  // Next-state and next-output logic for the transmit sequence.
  always_comb begin
    state_d   = state_q;
    icnt_d    = icnt_q;
    tcnt_d    = tcnt_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    nak_d     = nak_q;
    clk_oe_d  = hid_clk_oe;
    dat_oe_d  = hid_dat_oe;
    rx_inh_d  = rx_inhibit;
    ready_d   = 1'b0;
    done_d    = 1'b0;
    ack_err_d = 1'b0;
    tout_d    = 1'b0;
    end_ok    = 1'b0;
    end_nak   = 1'b0;
    end_to    = 1'b0;
`ifdef HID_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    if (timed) begin
      if (bus_edge)             tcnt_d = TW'(1);
      else if (tcnt_q != T_MAX) tcnt_d = tcnt_q + TW'(1);
    end

    // A stalled device clock overrides any edge seen in the same cycle.
    if (t_expire) begin
      end_to = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          ready_d = 1'b1;
          if (cmd.cmd_valid && ready_q) begin
            shreg_d  = cmd.cmd_data;
            par_d    = ~^cmd.cmd_data;
            nak_d    = 1'b0;
            icnt_d   = '0;
            clk_oe_d = 1'b1;
            dat_oe_d = 1'b0;
            rx_inh_d = 1'b1;
            ready_d  = 1'b0;
            state_d  = INHIBIT;
`ifdef HID_TX_RETRY_EN
            retry_d  = '0;
`endif
          end
        end
        INHIBIT: begin
          if (icnt_q == I_LAST) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b1;
            tcnt_d   = TW'(1);
            state_d  = RTS;
          end else begin
            icnt_d = icnt_q + IW'(1);
          end
        end
        RTS: begin
          if (c_fall) begin
            bitcnt_d = 3'd0;
            dat_oe_d = ~shreg_q[0];
            state_d  = DATA;
          end
        end
        DATA: begin
          if (c_fall) begin
            if (bitcnt_q == 3'd7) begin
              dat_oe_d = ~par_q;
              state_d  = PARITY;
            end else begin
              bitcnt_d = bit_nxt;
              dat_oe_d = ~shreg_q[bit_nxt];
            end
          end
        end
        PARITY: begin
          if (c_fall) begin
            dat_oe_d = 1'b0;
            state_d  = STOP;
          end
        end
        STOP: begin
          if (c_fall) state_d = ACK;
        end
        ACK: begin
          if (c_rise) begin
            nak_d   = dat_s2;
            state_d = FINISH;
          end
        end
        FINISH: begin
          if (clk_s2 && dat_s2) begin
            if (nak_q) end_nak = 1'b1;
            else       end_ok  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (end_ok || end_nak || end_to) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
`ifdef HID_TX_RETRY_EN
      if ((end_nak || end_to) && (retry_q < RW'(RETRY_MAX))) begin
        retry_d  = retry_q + RW'(1);
        icnt_d   = '0;
        nak_d    = 1'b0;
        clk_oe_d = 1'b1;
        state_d  = INHIBIT;
      end else
`endif
      begin
        rx_inh_d  = 1'b0;
        ready_d   = 1'b1;
        done_d    = 1'b1;
        ack_err_d = end_nak;
        tout_d    = end_to;
        state_d   = IDLE;
      end
    end
  end

endmodule
